// File: rtl/ahb_pe_info_if.sv
// AHB-Lite signal bundle between a PE-local bus master and the ahb_pe_info slave.
interface ahb_pe_info_if;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HREADY;
    logic        HSEL;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HADDR, HWDATA, HSIZE, HTRANS, HWRITE, HREADY, HSEL,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HADDR, HWDATA, HSIZE, HTRANS, HWRITE, HREADY, HSEL,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_pe_info.sv
// Per-PE information slave: mesh identity and geometry, 64-bit cycle counter with
// coherent high-word shadow, scratch word and done flag, with two-cycle AHB errors.
module ahb_pe_info #(
    parameter int X       = 0,
    parameter int Y       = 0,
    parameter int COORD_W = 2,
    parameter int MESH_X  = 4,
    parameter int MESH_Y  = 4
) (
    input  logic               HCLK,
    input  logic               HRESET,
    ahb_pe_info_if.slave       bus,
    output logic [COORD_W-1:0] Addr_X,
    output logic [COORD_W-1:0] Addr_Y,
    output logic               pe_done
);

    typedef enum logic [1:0] {
        RESP_OKAY,
        RESP_ERR1,
        RESP_ERR2
    } resp_state_t;

    localparam logic [2:0] REG_ID       = 3'd0;
    localparam logic [2:0] REG_GEOM     = 3'd1;
    localparam logic [2:0] REG_CYCLE_LO = 3'd2;
    localparam logic [2:0] REG_CYCLE_HI = 3'd3;
    localparam logic [2:0] REG_SCRATCH  = 3'd4;
    localparam logic [2:0] REG_CTRL     = 3'd5;

    localparam logic [15:0] PE_ID     = 16'(Y * MESH_X + X);
    localparam logic [3:0]  X_NIBBLE  = 4'(X);
    localparam logic [3:0]  Y_NIBBLE  = 4'(Y);
    localparam logic [31:0] ID_WORD   = {PE_ID, 8'h00, Y_NIBBLE, X_NIBBLE};
    localparam logic [31:0] GEOM_WORD = {16'h0000, 8'(MESH_Y), 8'(MESH_X)};

    resp_state_t state;
    logic        hreadyout_q;
    logic        hresp_q;

    logic [63:0] count;
    logic [31:0] shadow;
    logic [31:0] scratch;
    logic        done;

    logic        dp_sel;
    logic        dp_write;
    logic [2:0]  dp_reg;
    logic [2:0]  dp_size;
    logic [1:0]  dp_lane;

    logic        accept;
    logic        addr_err;
    logic        dp_ok;
    logic [31:0] rdata;
    logic        unused_bits;

    function automatic logic is_illegal(
        input logic [2:0] reg_idx,
        input logic       write,
        input logic [2:0] size,
        input logic [1:0] lane
    );
        return (write && (reg_idx <= REG_CYCLE_HI)) || (reg_idx >= 3'd6) ||
               (size != 3'b010) || (lane != 2'b00);
    endfunction

    assign accept   = bus.HSEL && bus.HREADY && bus.HTRANS[1];
    assign addr_err = is_illegal(bus.HADDR[4:2], bus.HWRITE, bus.HSIZE, bus.HADDR[1:0]);
    assign dp_ok    = dp_sel && !is_illegal(dp_reg, dp_write, dp_size, dp_lane);

    assign unused_bits = ^{bus.HADDR[31:5], bus.HTRANS[0]};

    // Response FSM: an erroring transfer costs one stalled ERROR cycle then one ready ERROR cycle.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state       <= RESP_OKAY;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            unique case (state)
                RESP_OKAY: begin
                    if (accept && addr_err) begin
                        state       <= RESP_ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= 1'b1;
                    end else begin
                        state       <= RESP_OKAY;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= 1'b0;
                    end
                end
                RESP_ERR1: begin
                    state       <= RESP_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b1;
                end
                RESP_ERR2: begin
                    if (accept && addr_err) begin
                        state       <= RESP_ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= 1'b1;
                    end else begin
                        state       <= RESP_OKAY;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= 1'b0;
                    end
                end
                default: begin
                    state       <= RESP_OKAY;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: free-running counter, data-phase capture and register writes.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            count    <= '0;
            shadow   <= '0;
            scratch  <= '0;
            done     <= 1'b0;
            dp_sel   <= 1'b0;
            dp_write <= 1'b0;
            dp_reg   <= '0;
            dp_size  <= '0;
            dp_lane  <= '0;
        end else begin
            count <= count + 64'd1;

            if (dp_ok && dp_write) begin
                if (dp_reg == REG_SCRATCH) begin
                    scratch <= bus.HWDATA;
                end
                if (dp_reg == REG_CTRL) begin
                    done <= bus.HWDATA[0];
                end
            end

            // Latching the high word on a LO read makes a following HI read coherent.
            if (dp_ok && !dp_write && (dp_reg == REG_CYCLE_LO)) begin
                shadow <= count[63:32];
            end

            dp_sel   <= accept;
            dp_write <= bus.HWRITE;
            dp_reg   <= bus.HADDR[4:2];
            dp_size  <= bus.HSIZE;
            dp_lane  <= bus.HADDR[1:0];
        end
    end

    always_comb begin
        rdata = '0;
        if (dp_ok && !dp_write) begin
            unique case (dp_reg)
                REG_ID:       rdata = ID_WORD;
                REG_GEOM:     rdata = GEOM_WORD;
                REG_CYCLE_LO: rdata = count[31:0];
                REG_CYCLE_HI: rdata = shadow;
                REG_SCRATCH:  rdata = scratch;
                REG_CTRL:     rdata = {31'b0, done};
                default:      rdata = '0;
            endcase
        end
    end

    assign bus.HRDATA    = rdata;
    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;
    assign pe_done       = done;
    assign Addr_X        = COORD_W'(X);
    assign Addr_Y        = COORD_W'(Y);

endmodule
